// File: rtl/ids_bus_mux.sv
// Two-master (DMEM, DMA) to single-port memory mux with in-order read response routing.
// Defining IDS_BUS_ADDR_CHECK_EN enables the memory window range check and error response.
module ids_bus_mux #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] MEM_BASE  = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] MEM_BYTES = 32'h0000_4000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_gnt_dmem,
    input  logic                  i_gnt_dma,
    input  logic                  i_dmem_req,
    input  logic                  i_dmem_we,
    input  logic [ADDR_W-1:0]     i_dmem_addr,
    input  logic [DATA_W/8-1:0]   i_dmem_be,
    input  logic [DATA_W-1:0]     i_dmem_wdata,
    output logic                  o_dmem_ack,
    output logic                  o_dmem_rvalid,
    output logic [DATA_W-1:0]     o_dmem_rdata,
    output logic                  o_dmem_err,
    input  logic                  i_dma_req,
    input  logic                  i_dma_we,
    input  logic [ADDR_W-1:0]     i_dma_addr,
    input  logic [DATA_W/8-1:0]   i_dma_be,
    input  logic [DATA_W-1:0]     i_dma_wdata,
    output logic                  o_dma_ack,
    output logic                  o_dma_rvalid,
    output logic [DATA_W-1:0]     o_dma_rdata,
    output logic                  o_dma_err,
    output logic                  o_mem_cs,
    output logic                  o_mem_we,
    output logic [ADDR_W-3:0]     o_mem_addr,
    output logic [DATA_W/8-1:0]   o_mem_be,
    output logic [DATA_W-1:0]     o_mem_wdata,
    input  logic [DATA_W-1:0]     i_mem_rdata
);
    localparam int                BE_W      = DATA_W / 8;
    localparam logic [ADDR_W-1:0] BYTE_MASK = MEM_BYTES - {{(ADDR_W-1){1'b0}}, 1'b1};

    logic                dmem_ack_s;
    logic                dma_ack_s;
    logic                accept_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [BE_W-1:0]     sel_be_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic [ADDR_W-1:0]   offset_s;
    logic [ADDR_W-1:0]   local_s;
    logic                in_range_s;
    logic                addr_lsb_unused_s;
    logic                resp_valid_r;
    logic                resp_dma_r;
    logic                resp_read_r;
    logic                resp_err_r;
    logic [DATA_W-1:0]   resp_data_s;
    logic                dmem_rvalid_s;
    logic                dma_rvalid_s;
    logic [DATA_W-1:0]   dmem_hold_r;
    logic [DATA_W-1:0]   dma_hold_r;

    // Ownership and acceptance; reset gates everything so the memory is quiet regardless of grants.
    always_comb begin
        dmem_ack_s = i_rst_n & i_gnt_dmem & i_dmem_req;
        dma_ack_s  = i_rst_n & ~i_gnt_dmem & i_gnt_dma & i_dma_req;
        accept_s   = dmem_ack_s | dma_ack_s;
        if (dma_ack_s) begin
            sel_we_s    = i_dma_we;
            sel_addr_s  = i_dma_addr;
            sel_be_s    = i_dma_be;
            sel_wdata_s = i_dma_wdata;
        end else begin
            sel_we_s    = i_dmem_we;
            sel_addr_s  = i_dmem_addr;
            sel_be_s    = i_dmem_be;
            sel_wdata_s = i_dmem_wdata;
        end
    end

    assign offset_s = sel_addr_s - MEM_BASE;

`ifdef IDS_BUS_ADDR_CHECK_EN
    assign in_range_s = (offset_s < MEM_BYTES);
    assign local_s    = offset_s;
`else
    // Without the check the window simply aliases; MEM_BYTES is expected to be a power of two.
    assign in_range_s = 1'b1;
    assign local_s    = offset_s & BYTE_MASK;
`endif

    assign addr_lsb_unused_s = ^local_s[1:0];

    // Memory port driven straight from the accepted request.
    always_comb begin
        o_mem_cs    = accept_s & in_range_s;
        o_mem_we    = accept_s & in_range_s & sel_we_s;
        o_mem_addr  = local_s[ADDR_W-1:2];
        o_mem_wdata = sel_wdata_s;
        if (accept_s && in_range_s) begin
            o_mem_be = sel_be_s;
        end else begin
            o_mem_be = {BE_W{1'b0}};
        end
    end

    // Response register: who issued the last accepted request and what comes back.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            resp_valid_r <= 1'b0;
            resp_dma_r   <= 1'b0;
            resp_read_r  <= 1'b0;
            resp_err_r   <= 1'b0;
        end else begin
            resp_valid_r <= accept_s;
            resp_dma_r   <= dma_ack_s;
            resp_read_r  <= accept_s & ~sel_we_s;
            resp_err_r   <= accept_s & ~in_range_s;
        end
    end

    assign resp_data_s   = resp_err_r ? {DATA_W{1'b0}} : i_mem_rdata;
    assign dmem_rvalid_s = resp_valid_r & resp_read_r & ~resp_dma_r;
    assign dma_rvalid_s  = resp_valid_r & resp_read_r & resp_dma_r;

    // Per-master read data hold between that master's own rvalid pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dmem_hold_r <= {DATA_W{1'b0}};
            dma_hold_r  <= {DATA_W{1'b0}};
        end else begin
            if (dmem_rvalid_s) begin
                dmem_hold_r <= resp_data_s;
            end else begin
                dmem_hold_r <= dmem_hold_r;
            end
            if (dma_rvalid_s) begin
                dma_hold_r <= resp_data_s;
            end else begin
                dma_hold_r <= dma_hold_r;
            end
        end
    end

    assign o_dmem_ack    = dmem_ack_s;
    assign o_dma_ack     = dma_ack_s;
    assign o_dmem_rvalid = dmem_rvalid_s;
    assign o_dma_rvalid  = dma_rvalid_s;
    assign o_dmem_rdata  = dmem_rvalid_s ? resp_data_s : dmem_hold_r;
    assign o_dma_rdata   = dma_rvalid_s ? resp_data_s : dma_hold_r;
    assign o_dmem_err    = resp_valid_r & resp_err_r & ~resp_dma_r;
    assign o_dma_err     = resp_valid_r & resp_err_r & resp_dma_r;

endmodule

// File: tb/tb_ids_bus_mux.sv
// Scoreboard bench for ids_bus_mux: random and directed traffic against a word-array reference model.
module tb_ids_bus_mux;
    localparam int          WORDS     = 4096;
    localparam int unsigned MEM_BYTES = 32'h0000_4000;
    localparam int unsigned MEM_BASE  = 32'h0000_0000;
`ifdef IDS_BUS_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        gnt_dmem = 1'b0, gnt_dma = 1'b0;
    logic        dmem_req = 1'b0, dmem_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dmem_addr = 32'h0, dma_addr = 32'h0, dmem_wdata = 32'h0, dma_wdata = 32'h0;
    logic [3:0]  dmem_be = 4'h0, dma_be = 4'h0;
    logic        dmem_ack, dmem_rvalid, dmem_err, dma_ack, dma_rvalid, dma_err;
    logic [31:0] dmem_rdata, dma_rdata;
    logic        mem_cs, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    ids_bus_mux #(.ADDR_W(32), .DATA_W(32), .MEM_BASE(32'h0000_0000), .MEM_BYTES(32'h0000_4000)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_gnt_dmem(gnt_dmem), .i_gnt_dma(gnt_dma),
        .i_dmem_req(dmem_req), .i_dmem_we(dmem_we), .i_dmem_addr(dmem_addr), .i_dmem_be(dmem_be),
        .i_dmem_wdata(dmem_wdata), .o_dmem_ack(dmem_ack), .o_dmem_rvalid(dmem_rvalid),
        .o_dmem_rdata(dmem_rdata), .o_dmem_err(dmem_err),
        .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_be(dma_be),
        .i_dma_wdata(dma_wdata), .o_dma_ack(dma_ack), .o_dma_rvalid(dma_rvalid),
        .o_dma_rdata(dma_rdata), .o_dma_err(dma_err),
        .o_mem_cs(mem_cs), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_be(mem_be),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment memory behind the DUT's memory port.
    logic [31:0] bmem [0:WORDS-1] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) bmem[mem_addr[11:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= bmem[mem_addr[11:0]];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit dma; bit rd; bit err; logic [31:0] data; int due; } exp_t;
    exp_t        sbq[$];
    logic [31:0] ref_mem [0:WORDS-1] = '{default: 32'h0};
    logic [31:0] hold [0:1] = '{32'h0, 32'h0};
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One bus cycle: drive both masters, predict acceptance and memory port, queue expected response.
    task automatic step(input bit gd, input bit gm,
                        input bit dreq, input bit dwe, input logic [31:0] da, input logic [3:0] dbe, input logic [31:0] dwd,
                        input bit mreq, input bit mwe, input logic [31:0] ma, input logic [3:0] mbe, input logic [31:0] mwd);
        bit          e_dack, e_mack, is_dma, we, inr;
        logic [31:0] a, wd;
        logic [3:0]  be;
        int unsigned off, idx;
        exp_t        e;
        gnt_dmem = gd; gnt_dma = gm;
        dmem_req = dreq; dmem_we = dwe; dmem_addr = da; dmem_be = dbe; dmem_wdata = dwd;
        dma_req = mreq; dma_we = mwe; dma_addr = ma; dma_be = mbe; dma_wdata = mwd;
        @(negedge clk);
        e_dack = gd && dreq;
        e_mack = !gd && gm && mreq;
        chk("dmem_ack", {31'h0, dmem_ack}, {31'h0, e_dack});
        chk("dma_ack", {31'h0, dma_ack}, {31'h0, e_mack});
        if (e_dack || e_mack) begin
            is_dma = e_mack;
            a  = is_dma ? ma : da;
            we = is_dma ? mwe : dwe;
            be = is_dma ? mbe : dbe;
            wd = is_dma ? mwd : dwd;
            off = a - MEM_BASE;
            inr = CHECK_EN ? (off < MEM_BYTES) : 1'b1;
            idx = (off % MEM_BYTES) / 4;
            if (inr) begin
                chk("mem_cs", {31'h0, mem_cs}, 32'h1);
                chk("mem_we", {31'h0, mem_we}, {31'h0, we});
                chk("mem_addr", {2'b00, mem_addr}, idx);
                chk("mem_be", {28'h0, mem_be}, {28'h0, be});
                if (we) begin
                    chk("mem_wdata", mem_wdata, wd);
                    for (int b = 0; b < 4; b++)
                        if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    e = '{dma: is_dma, rd: 1'b1, err: 1'b0, data: ref_mem[idx], due: cyc + 1};
                    sbq.push_back(e);
                end
            end else begin
                chk("mem_cs_oor", {31'h0, mem_cs}, 32'h0);
                e = '{dma: is_dma, rd: !we, err: 1'b1, data: 32'h0, due: cyc + 1};
                sbq.push_back(e);
            end
        end else begin
            chk("mem_cs_idle", {31'h0, mem_cs}, 32'h0);
            chk("mem_we_idle", {31'h0, mem_we}, 32'h0);
            chk("mem_be_idle", {28'h0, mem_be}, 32'h0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // Reset drops any pending response and clears the held read data.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        sbq.delete();
        hold[0] = 32'h0;
        hold[1] = 32'h0;
        gnt_dmem = 1'b1; gnt_dma = 1'b1; dmem_req = 1'b1; dma_req = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pops expected responses whenever a port presents rvalid/err, checks holds otherwise.
    initial begin
        bit          rv, er;
        logic [31:0] rd;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_outputs",
                    {24'h0, dmem_rvalid, dma_rvalid, dmem_err, dma_err, mem_cs, mem_we, dmem_ack, dma_ack}, 32'h0);
                chk("rst_dmem_rdata", dmem_rdata, 32'h0);
                chk("rst_dma_rdata", dma_rdata, 32'h0);
            end else begin
                for (int p = 0; p < 2; p++) begin
                    rv = (p == 0) ? dmem_rvalid : dma_rvalid;
                    er = (p == 0) ? dmem_err : dma_err;
                    rd = (p == 0) ? dmem_rdata : dma_rdata;
                    if (rv || er) begin
                        vectors++;
                        if (sbq.size() == 0 || sbq[0].dma != p[0] || sbq[0].due != cyc) begin
                            miscompares++;
                            $display("FAIL unexpected_resp port %0d at cycle %0d: got rvalid=%0b err=%0b expected no response",
                                     p, cyc, rv, er);
                        end else begin
                            e = sbq.pop_front();
                            chk("resp_rvalid", {31'h0, rv}, {31'h0, e.rd});
                            chk("resp_err", {31'h0, er}, {31'h0, e.err});
                            if (e.rd) begin
                                chk(p == 0 ? "dmem_rdata" : "dma_rdata", rd, e.data);
                                hold[p] = e.data;
                            end
                        end
                    end else begin
                        chk(p == 0 ? "dmem_rdata_hold" : "dma_rdata_hold", rd, hold[p]);
                    end
                end
                while (sbq.size() != 0 && sbq[0].due <= cyc) begin
                    e = sbq.pop_front();
                    vectors++;
                    miscompares++;
                    $display("FAIL missing_resp port %0d at cycle %0d: got none expected response due %0d",
                             e.dma, cyc, e.due);
                end
            end
        end
    end

    initial begin
        logic [31:0] a1, a2;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle();
        // Seed word 4, then DMEM read of 0x10 returns it on the next cycle.
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        idle();
        // DMA partial write at 0x20, no response expected.
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h20, 4'b0011, 32'h1234_5678);
        idle();
        // Ownership switch: DMEM read then DMA read, back to back.
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        idle();
        idle();
        // Both grants high: DMEM wins.
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h80, 4'hC, 32'hA5A5_5A5A, 1'b1, 1'b1, 32'h84, 4'hF, 32'h0F0F_0F0F);
        // Unaligned read truncates to word 4; out-of-window address wraps or errors.
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h13, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h8000, 4'hF, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h4084, 4'hF, 32'h0);
        idle();
        // Reset the cycle after an accepted read: its rvalid must never appear.
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        do_reset(2);
        idle();
        idle();
        for (int i = 0; i < 3000; i++) begin
            a1 = $urandom_range(0, 2 * MEM_BYTES - 1);
            a2 = $urandom_range(0, 2 * MEM_BYTES - 1);
            if ($urandom_range(0, 3) != 0) a1[13] = 1'b0;
            if ($urandom_range(0, 3) != 0) a2[13] = 1'b0;
            a1[12:8] = 5'h0;
            a2[12:8] = 5'h0;
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a1, 4'($urandom), $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a2, 4'($urandom), $urandom);
        end
        idle();
        idle();
        chk("queue_drained", sbq.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
